// File: rtl/shift_arbiter.sv
// -----------------------------------------------------------------------------
// shift_arbiter
//   Shares one barrel shifter between two requesters using round-robin
//   arbitration. The winning request is shifted combinationally. The result is
//   captured into a single registered response stage, tagged with the
//   requester ID.
//
// Ports
//   clk, rst            clock / asynchronous active-high reset
//   req0_*  / req1_*    request ports: valid/ready handshake with operand d,
//                       shift amount sa, direction right (1=right, 0=left) and
//                       arith (sign-fill on right shifts)
//   rsp_valid/rsp_ready response handshake
//   rsp_id              requester that issued the held result
//   rsp_sh              shifted result
// -----------------------------------------------------------------------------
module shift_arbiter #(
  parameter int WIDTH = 32,
  parameter int SAW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_d,
  input  logic [SAW-1:0]   req0_sa,
  input  logic             req0_right,
  input  logic             req0_arith,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_d,
  input  logic [SAW-1:0]   req1_sa,
  input  logic             req1_right,
  input  logic             req1_arith,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sh
);

  logic             rsp_valid_reg;
  logic             rsp_id_reg;
  logic [WIDTH-1:0] rsp_sh_reg;
  logic             last_grant_reg;

  logic             can_accept;
  logic             grant0;
  logic             grant1;
  logic             any_grant;

  logic [WIDTH-1:0] sel_d;
  logic [SAW-1:0]   sel_sa;
  logic             sel_right;
  logic             sel_arith;
  logic             fill;
  logic [WIDTH-1:0] rev_d;
  logic [WIDTH-1:0] rev_out;
  logic [WIDTH-1:0] stage [SAW+1];
  logic [WIDTH-1:0] rsp_sh_next;

  // Readies are forced low while reset is held, not just after the next edge.
  assign can_accept = !rst && (!rsp_valid_reg || rsp_ready);

  // On contention the requester that did not win last time takes the slot.
  assign grant0    = can_accept && req0_valid && (!req1_valid || last_grant_reg);
  assign grant1    = can_accept && req1_valid && (!req0_valid || !last_grant_reg);
  assign any_grant = grant0 || grant1;

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // The shifter input only matters when a grant is made, so the select
  // simply follows grant1.
  assign sel_d     = grant1 ? req1_d     : req0_d;
  assign sel_sa    = grant1 ? req1_sa    : req0_sa;
  assign sel_right = grant1 ? req1_right : req0_right;
  assign sel_arith = grant1 ? req1_arith : req0_arith;

  // A single right-shifting barrel handles both directions. Left shifts
  // bit-reverse the operand on the way in and on the way out. Arith is
  // ignored for left shifts because fill is zero unless sel_right is set.
  assign fill = sel_right && sel_arith && sel_d[WIDTH-1];

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rev
      assign rev_d[gi]   = sel_d[WIDTH-1-gi];
      assign rev_out[gi] = stage[SAW][WIDTH-1-gi];
    end
  endgenerate

  assign stage[0] = sel_right ? sel_d : rev_d;

  generate
    for (genvar gi = 0; gi < SAW; gi++) begin : g_stage
      localparam int STEP = 1 << gi;
      assign stage[gi+1] = sel_sa[gi] ? {{STEP{fill}}, stage[gi][WIDTH-1:STEP]}
                                      : stage[gi];
    end
  endgenerate

  assign rsp_sh_next = sel_right ? stage[SAW] : rev_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_reg  <= 1'b0;
      rsp_id_reg     <= 1'b0;
      rsp_sh_reg     <= '0;
      last_grant_reg <= 1'b1;
    end else if (any_grant) begin
      rsp_valid_reg  <= 1'b1;
      rsp_id_reg     <= grant1;
      rsp_sh_reg     <= rsp_sh_next;
      last_grant_reg <= grant1;
    end else if (rsp_ready) begin
      // Drain without refill: the payload holds its last value.
      rsp_valid_reg <= 1'b0;
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_id    = rsp_id_reg;
  assign rsp_sh    = rsp_sh_reg;

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Shares one 32-bit barrel shifter (the team's `shift` module: d, sa, right, arith -> sh) between two requesters.
- Round-robin arbitration, valid/ready handshakes on both request ports and on the response port.
- One registered result stage; each response is tagged with the originating requester ID.
- Sits between the ALU issue logic and any unit needing shifts, such as the multi-cycle multiply/divide sequencers.

Parameters:
- WIDTH, 32, datapath width; must equal the shifter width.
- SAW, 5, shift-amount width, log2(WIDTH).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_d  input  WIDTH  requester 0 operand.
- req0_sa  input  SAW  requester 0 shift amount.
- req0_right  input  1  requester 0 direction; 1 = right, 0 = left.
- req0_arith  input  1  requester 0 arithmetic right shift; ignored when right=0.
- req1_valid, req1_ready, req1_d, req1_sa, req1_right, req1_arith: same as requester 0, for requester 1.
- rsp_valid  output  1  result register holds a result.
- rsp_ready  input  1  consumer accepts the result.
- rsp_id  output  1  requester that issued the held result.
- rsp_sh  output  WIDTH  shifted result.

Behaviour:
- Reset (async, immediate):
  - rsp_valid=0, rsp_id=0, rsp_sh=0.
  - last_grant=1, so requester 0 wins the first contention.
  - req0_ready and req1_ready drop to 0 with rsp_valid cleared; no other state survives.
- Slot free: `can_accept = !rsp_valid || rsp_ready`. Draining and refilling in the same cycle is allowed, giving full throughput of 1 op/cycle.
- Arbitration (combinational, only when can_accept):
  - Exactly one valid requester: grant it.
  - Both valid: grant the one that is not last_grant.
  - Neither valid: no grant.
  - reqN_ready = grant to N. A requester is never granted while can_accept=0.
- Capture on the clock edge with a grant:
  - rsp_sh <= shift(d, sa, right, arith) of the granted port.
  - rsp_id <= granted index; rsp_valid <= 1; last_grant <= granted index.
- Drain without refill: on rsp_valid && rsp_ready with no grant, rsp_valid <= 0. rsp_sh and rsp_id hold their last values.
- Backpressure: while rsp_valid && !rsp_ready, rsp_sh and rsp_id are stable and no request is accepted.
- Latency: request accepted on edge N -> rsp_valid=1 with the result after edge N.
- Shift rules (unchanged from the shifter):
  - Left: zero-fill.
  - Right, arith=0: zero-fill.
  - Right, arith=1: replicate d[WIDTH-1].
  - sa=0: passthrough.
  - sa=WIDTH-1: maximum shift.
- Requester rules:
  - Must hold valid and payload stable until ready.
  - A requester that deasserts valid before ready forfeits its turn.
  - last_grant changes only on an actual grant.
- Fairness: under continuous dual requests with rsp_ready=1, grants strictly alternate 0,1,0,1.
- Reset mid-operation: an in-flight result is discarded; no response for it is ever produced.

Test Plan:
- Single request: after reset, req0 d=0x8000FFFF, sa=5, right=0, arith=0, rsp_ready=1 -> req0_ready=1 that cycle; next cycle rsp_valid=1, rsp_id=0, rsp_sh=0x001FFFE0.
- Shift modes via req1:
  - d=0x8000FFFF, sa=5, right=1, arith=0 -> rsp_sh=0x040007FF.
  - sa=16, right=1, arith=1 -> 0xFFFF8000.
  - sa=16, right=0, arith=1 -> 0xFFFF0000 (arith ignored).
  - sa=0 -> 0x8000FFFF.
- Contention: both valid continuously for 4 cycles, rsp_ready=1 -> accepted IDs 0,1,0,1; rsp_id sequence 0,1,0,1 one cycle later; one response per cycle.
- Backpressure: result held with rsp_ready=0 for 3 cycles and req0 valid -> req0_ready=0; rsp_sh/rsp_id stable. Raise rsp_ready -> req0 accepted that same cycle; new result next cycle.
- Reset mid-operation: assert rst while rsp_valid=1 with rsp_ready=0 -> rsp_valid=0 immediately (before next edge). After release, with both requesters valid, requester 0 is granted first.
